// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory port.
// Defines the response source tag and the macro word-address width.
package mem_port_arbiter_pkg;

    localparam int MEM_ADDR_W = 22;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_DATA  = 2'd1,
        SRC_FETCH = 2'd2
    } mem_src_e;

endpackage

// File: rtl/mem_port_arbiter_fetch_line_buffer.sv
// One-entry fetch buffer: filled from fetch responses, looked up combinationally, invalidated by data writes.
// Lookup is 0-cycle; fill and invalidate take effect at the next edge; never stalls.
module fetch_line_buffer
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [31:0]       fill_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [31:0]       hit_data
);

    logic              vld_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic              wr_same;

    // A write to the buffered word must not be served as a hit in the same cycle.
    assign wr_same  = wr_en && (wr_addr == addr_q);
    assign hit      = vld_q && (addr_q == lookup_addr) && !wr_same;
    assign hit_data = data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (fill_en) begin
            addr_q <= fill_addr;
            data_q <= fill_data;
            vld_q  <= !(wr_en && (wr_addr == fill_addr));
        end else if (wr_same) begin
            vld_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between the fetch port and the data port; data always wins.
// Responses 1 cycle after request; fetch stalls via inst_ready=0 unless the fetch buffer hits.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       inst_addr,
    output logic [31:0]       instruction,
    output logic              inst_ready,
    input  logic              sram_cen,
    input  logic              sram_wen,
    input  logic [3:0]        sram_ben,
    input  logic [31:0]       sram_addr,
    input  logic [31:0]       sram_din,
    output logic [31:0]       sram_dout,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic [3:0]        mem_ben,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic [CNT_W-1:0]  stall_count
);

    logic [ADDR_W-1:0] inst_word;
    logic [ADDR_W-1:0] data_word;
    logic              data_req;
    logic              data_wr;

    mem_src_e          src_q;
    logic [ADDR_W-1:0] fetch_addr_q;
    logic              hit_q;
    logic [31:0]       hit_data_q;
    logic [31:0]       instr_q;
    logic [CNT_W-1:0]  stall_q;

    logic              buf_hit;
    logic [31:0]       buf_data;
    logic              stall;
    logic              unused_addr_bits;

    assign inst_word        = inst_addr[ADDR_W+1:2];
    assign data_word        = sram_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0],
                                sram_addr[31:ADDR_W+2], sram_addr[1:0]};
    assign data_req         = !sram_cen;
    assign data_wr          = data_req && !sram_wen && (sram_ben != 4'hF);

    always_comb begin
        mem_cen  = 1'b0;
        mem_wen  = 1'b1;
        mem_ben  = 4'b0000;
        mem_addr = inst_word;
        mem_din  = '0;
        if (!rst_n) begin
            mem_cen = 1'b1;
        end else if (data_req) begin
            mem_wen  = sram_wen;
            mem_ben  = sram_ben;
            mem_addr = data_word;
            mem_din  = sram_din;
        end
    end

    fetch_line_buffer #(
        .ADDR_W (ADDR_W)
    ) u_fetch_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .fill_en     (src_q == SRC_FETCH),
        .fill_addr   (fetch_addr_q),
        .fill_data   (mem_dout),
        .wr_en       (data_wr),
        .wr_addr     (data_word),
        .lookup_addr (inst_word),
        .hit         (buf_hit),
        .hit_data    (buf_data)
    );

    // Reset is honoured combinationally so responses are quiet as soon as rst_n drops.
    always_comb begin
        instruction = instr_q;
        inst_ready  = 1'b0;
        sram_dout   = '0;
        if (!rst_n) begin
            instruction = NOP;
        end else begin
            if (src_q == SRC_DATA)
                sram_dout = mem_dout;
            if (src_q == SRC_FETCH) begin
                instruction = mem_dout;
                inst_ready  = 1'b1;
            end else if (src_q == SRC_DATA && hit_q) begin
                instruction = hit_data_q;
                inst_ready  = 1'b1;
            end
        end
    end

    // The first cycle after reset answers no request, so it is not a stall.
    assign stall       = (src_q != SRC_NONE) && !inst_ready;
    assign stall_count = stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_q        <= SRC_NONE;
            fetch_addr_q <= '0;
            hit_q        <= 1'b0;
            hit_data_q   <= '0;
            instr_q      <= NOP;
            stall_q      <= '0;
        end else begin
            src_q        <= data_req ? SRC_DATA : SRC_FETCH;
            fetch_addr_q <= inst_word;
            hit_q        <= data_req && buf_hit;
            hit_data_q   <= buf_data;
            instr_q      <= instruction;
            if (stall && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural 1-cycle SRAM macro.
// Each driven cycle pushes the expected next-cycle response; a monitor pops and compares.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_addr;
    logic [31:0] instruction;
    logic        inst_ready;
    logic        sram_cen;
    logic        sram_wen;
    logic [3:0]  sram_ben;
    logic [31:0] sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;
    logic        mem_cen;
    logic        mem_wen;
    logic [3:0]  mem_ben;
    logic [21:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic [31:0] stall_count;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_addr   (inst_addr),
        .instruction (instruction),
        .inst_ready  (inst_ready),
        .sram_cen    (sram_cen),
        .sram_wen    (sram_wen),
        .sram_ben    (sram_ben),
        .sram_addr   (sram_addr),
        .sram_din    (sram_din),
        .sram_dout   (sram_dout),
        .mem_cen     (mem_cen),
        .mem_wen     (mem_wen),
        .mem_ben     (mem_ben),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout),
        .stall_count (stall_count)
    );

    // Behavioural macro: 1-cycle read, write returns the merged (new) word.
    logic [31:0] mem_arr [0:255];
    logic        unused_tb;
    assign unused_tb = ^mem_addr[21:8];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] ben);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (!ben[i]) r[8*i +: 8] = din[8*i +: 8];
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        mem_arr[1]    = 32'hAAAA0001;
        mem_arr[2]    = 32'hBBBB0002;
        mem_arr[3]    = 32'hCCCC0003;
        mem_arr[8'h40] = 32'hCAFE0040;
        mem_dout      = 32'h0;
    end

    always @(posedge clk) begin
        if (!mem_cen) begin
            if (!mem_wen) begin
                mem_arr[mem_addr[7:0]] <= merge(mem_arr[mem_addr[7:0]], mem_din, mem_ben);
                mem_dout               <= merge(mem_arr[mem_addr[7:0]], mem_din, mem_ben);
            end else begin
                mem_dout <= mem_arr[mem_addr[7:0]];
            end
        end
    end

    typedef struct packed {
        logic        rdy;
        logic [31:0] ins;
        logic [31:0] dout;
        logic [31:0] cnt;
        logic        mcen;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   rec      = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s rec=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("inst_ready",  rec, {31'h0, inst_ready}, {31'h0, e.rdy});
                chk("instruction", rec, instruction, e.ins);
                chk("sram_dout",   rec, sram_dout, e.dout);
                chk("stall_count", rec, stall_count, e.cnt);
                chk("mem_cen",     rec, {31'h0, mem_cen}, {31'h0, e.mcen});
                rec++;
            end
        end
    end

    // Drive one cycle of inputs and queue the response expected in the following cycle.
    task automatic cyc(input logic r, input logic [31:0] ia, input logic c, input logic w,
                       input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                       input logic e_rdy, input logic [31:0] e_ins,
                       input logic [31:0] e_dout, input logic [31:0] e_cnt);
        @(negedge clk);
        rst_n     = r;
        inst_addr = ia;
        sram_cen  = c;
        sram_wen  = w;
        sram_ben  = b;
        sram_addr = a;
        sram_din  = d;
        sb.push_back('{rdy: e_rdy, ins: e_ins, dout: e_dout, cnt: e_cnt, mcen: !r});
    endtask

    task automatic fetch(input logic r, input logic [31:0] ia, input logic e_rdy,
                         input logic [31:0] e_ins, input logic [31:0] e_dout,
                         input logic [31:0] e_cnt);
        cyc(r, ia, 1'b1, 1'b1, 4'hF, 32'h0, 32'h0, e_rdy, e_ins, e_dout, e_cnt);
    endtask

    localparam logic [31:0] NOP_W = 32'h00000013;

    initial begin : stim
        rst_n = 1'b0; inst_addr = 32'h0; sram_cen = 1'b1; sram_wen = 1'b1;
        sram_ben = 4'hF; sram_addr = 32'h0; sram_din = 32'h0;

        for (int i = 0; i < 5; i++)
            fetch(1'b0, 32'h0, 1'b0, NOP_W, 32'h0, 32'h0);

        // Plain fetches
        fetch(1'b1, 32'h4, 1'b1, 32'hAAAA0001, 32'h0, 32'h0);
        fetch(1'b1, 32'h8, 1'b1, 32'hBBBB0002, 32'h0, 32'h0);
        // Conflict miss: data read 0x100 vs fetch 0xC
        cyc(1'b1, 32'hC, 1'b0, 1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 32'hBBBB0002, 32'hCAFE0040, 32'h0);
        fetch(1'b1, 32'h8, 1'b1, 32'hBBBB0002, 32'h0, 32'h1);
        // Conflict hit on buffered word 2
        cyc(1'b1, 32'h8, 1'b0, 1'b1, 4'h0, 32'h100, 32'h0, 1'b1, 32'hBBBB0002, 32'hCAFE0040, 32'h1);
        // Write to the buffered word: no hit, buffer invalidated
        cyc(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h8, 32'h12345678, 1'b0, 32'hBBBB0002, 32'h12345678, 32'h1);
        fetch(1'b1, 32'h8, 1'b1, 32'h12345678, 32'h0, 32'h2);
        cyc(1'b1, 32'h8, 1'b0, 1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 32'h12345678, 32'hCAFE0040, 32'h2);
        cyc(1'b1, 32'h8, 1'b0, 1'b1, 4'h0, 32'h100, 32'h0, 1'b1, 32'h12345678, 32'hCAFE0040, 32'h3);
        // Byte write lane 0, then reset during its response cycle
        cyc(1'b1, 32'h4, 1'b0, 1'b0, 4'hE, 32'h100, 32'h000000EE, 1'b0, 32'h12345678, 32'hCAFE00EE, 32'h3);
        fetch(1'b0, 32'h8, 1'b0, NOP_W, 32'h0, 32'h0);
        // Buffer empty after reset: data read with inst_addr=0x8 must stall
        cyc(1'b1, 32'h8, 1'b0, 1'b1, 4'h0, 32'h8, 32'h0, 1'b0, NOP_W, 32'h12345678, 32'h0);
        fetch(1'b1, 32'h100, 1'b1, 32'hCAFE00EE, 32'h0, 32'h1);
        // High and low address bits are ignored
        fetch(1'b1, 32'hFF000009, 1'b1, 32'h12345678, 32'h0, 32'h1);
        // Write coinciding with a fill of the same word leaves the buffer invalid
        cyc(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h8, 32'h55AA55AA, 1'b0, 32'h12345678, 32'h55AA55AA, 32'h1);
        cyc(1'b1, 32'h8, 1'b0, 1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 32'h12345678, 32'hCAFE00EE, 32'h2);
        fetch(1'b1, 32'h8, 1'b1, 32'h55AA55AA, 32'h0, 32'h3);
        fetch(1'b1, 32'hC, 1'b1, 32'hCCCC0003, 32'h0, 32'h3);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
